// File: rtl/adder_result_display.sv
// Captures an upstream 2-bit adder's operands and result, flags sum mismatches and
// multiplexes a, b, cin and the result onto a 4-digit active-low seven-segment display.
module adder_result_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  input  logic [1:0] s,
  input  logic       cout,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err_led,
  output logic [7:0] err_count
);

  localparam int unsigned PresW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(REFRESH_DIV - 1);

  logic [PresW-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [2:0]       res_q, res_d;
  logic             shown_q, shown_d;
  logic             err_led_q, err_led_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [2:0] exp_sum;
  logic       mismatch;
  logic [2:0] digit;
  logic [6:0] digit_seg;

  always_comb begin
    exp_sum  = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    mismatch = ({cout, s} != exp_sum);
  end

  // Scan prescaler and digit index run regardless of load or shown.
  always_comb begin
    presc_d = presc_q + PresW'(1);
    idx_d   = idx_q;
    if (presc_q == PresMax) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    res_d     = res_q;
    shown_d   = shown_q;
    err_led_d = err_led_q;
    err_cnt_d = err_cnt_q;
    if (load) begin
      a_d       = a;
      b_d       = b;
      cin_d     = cin;
      res_d     = {cout, s};
      shown_d   = 1'b1;
      err_led_d = mismatch;
      if (mismatch && (err_cnt_q != 8'hff)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    digit = 3'd0;
    unique case (idx_q)
      2'd0: digit = res_q;
      2'd1: digit = {2'b00, cin_q};
      2'd2: digit = {1'b0, b_q};
      2'd3: digit = {1'b0, a_q};
      default: digit = 3'd0;
    endcase
  end

  // Cathode order {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    digit_seg = 7'b1111111;
    case (digit)
      3'd0: digit_seg = 7'b1000000;
      3'd1: digit_seg = 7'b1111001;
      3'd2: digit_seg = 7'b0100100;
      3'd3: digit_seg = 7'b0110000;
      3'd4: digit_seg = 7'b0011001;
      3'd5: digit_seg = 7'b0010010;
      3'd6: digit_seg = 7'b0000010;
      3'd7: digit_seg = 7'b1111000;
      default: digit_seg = 7'b1111111;
    endcase
  end

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (shown_q) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = digit_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= 2'd0;
      a_q       <= 2'd0;
      b_q       <= 2'd0;
      cin_q     <= 1'b0;
      res_q     <= 3'd0;
      shown_q   <= 1'b0;
      err_led_q <= 1'b0;
      err_cnt_q <= 8'd0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      res_q     <= res_d;
      shown_q   <= shown_d;
      err_led_q <= err_led_d;
      err_cnt_q <= err_cnt_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign err_led   = err_led_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_adder_result_display.sv
// Self-checking bench for adder_result_display: vector table for capture/scan,
// a display scoreboard, and hand-written sequences for reset/saturation corners.
module tb_adder_result_display;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset, load, cin, cout;
  logic [1:0] a, b, s;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, err_led;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  adder_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .s        (s),
    .cout     (cout),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .err_led  (err_led),
    .err_count(err_count)
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic       cout;
    logic [1:0] s;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } disp_t;

  vec_t  vecs[8];
  disp_t sb_q[$];
  int    cyc;
  int    n_checks;
  int    n_pass;

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd0: return 7'b1000000;
      3'd1: return 7'b1111001;
      3'd2: return 7'b0100100;
      3'd3: return 7'b0110000;
      3'd4: return 7'b0011001;
      3'd5: return 7'b0010010;
      3'd6: return 7'b0000010;
      default: return 7'b1111000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    tick();
    cyc   = 0;
    reset = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    a    = v.a;
    b    = v.b;
    cin  = v.cin;
    cout = v.cout;
    s    = v.s;
  endtask

  // Issues a one-cycle load so that it is sampled on edge number c after reset.
  task automatic load_at(input vec_t v, input int c);
    while (cyc < c - 1) tick();
    drive(v);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Output seen after edge c reflects the scan slot held after edge c-1.
  task automatic push_scan(input vec_t v, input int from_c, input int n);
    for (int c = from_c + 1; c <= from_c + n; c++) begin
      int         k;
      logic [2:0] d;
      disp_t      e;
      k = ((c - 1) / DIV) % 4;
      case (k)
        0:       d = {v.cout, v.s};
        1:       d = {2'b00, v.cin};
        2:       d = {1'b0, v.b};
        default: d = {1'b0, v.a};
      endcase
      e.an  = ~(4'b0001 << k);
      e.seg = seg_of(d);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input string name, input int n);
    disp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sb_q.size() == 0) begin
        check({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check(name, {an, seg}, {e.an, e.seg});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    reset    = 1'b1;
    load     = 1'b0;
    a = 2'd0; b = 2'd0; cin = 1'b0; cout = 1'b0; s = 2'd0;

    vecs[0] = '{2'd3, 2'd2, 1'b1, 1'b1, 2'd2, 1'b0};
    vecs[1] = '{2'd1, 2'd1, 1'b0, 1'b0, 2'd3, 1'b1};
    vecs[2] = '{2'd1, 2'd1, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[3] = '{2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[4] = '{2'd3, 2'd3, 1'b1, 1'b1, 2'd3, 1'b0};
    vecs[5] = '{2'd2, 2'd1, 1'b0, 1'b1, 2'd0, 1'b1};
    vecs[6] = '{2'd0, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1};
    vecs[7] = '{2'd2, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0};

    // Reset state and idle blank display.
    do_reset();
    check("reset_state", {an, seg, dp, err_led, err_count}, {4'hf, 7'h7f, 1'b1, 1'b0, 8'h00});
    for (int i = 0; i < 40; i++) begin
      tick();
      check("idle_blank", {an, seg, dp, err_led, err_count}, {4'hf, 7'h7f, 1'b1, 1'b0, 8'h00});
    end

    // Table: slot-aligned load, then a full 16-cycle scan.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      load_at(vecs[i], 16);
      check("vec_err_led", err_led, vecs[i].exp_err);
      check("vec_err_count", err_count, {7'd0, vecs[i].exp_err});
      push_scan(vecs[i], 16, 16);
      drain("vec_scan", 16);
    end

    // Mismatch then back-to-back matching load.
    do_reset();
    load_at(vecs[1], 3);
    check("mis_err_led", err_led, 1'b1);
    check("mis_err_count", err_count, 8'd1);
    drive(vecs[2]);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("match_err_led", err_led, 1'b0);
    check("match_err_count", err_count, 8'd1);
    push_scan(vecs[2], cyc, 8);
    drain("b2b_scan", 8);

    // Mid-slot loads must not disturb the scan phase.
    do_reset();
    load_at(vecs[5], 6);
    push_scan(vecs[5], 6, 12);
    drain("midslot_scan", 12);
    load_at(vecs[7], 21);
    check("midslot_err_led", err_led, 1'b0);
    check("midslot_err_count", err_count, 8'd1);
    push_scan(vecs[7], 21, 8);
    drain("reload_scan", 8);

    // Saturation over 300 consecutive mismatching loads.
    do_reset();
    drive(vecs[1]);
    load = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      check("sat_count", err_count, (i < 255) ? i : 255);
    end
    load = 1'b0;
    check("sat_err_led", err_led, 1'b1);

    // Reset beats a simultaneous mismatching load.
    reset = 1'b1;
    load  = 1'b1;
    drive(vecs[1]);
    tick();
    reset = 1'b0;
    load  = 1'b0;
    cyc   = 0;
    check("rst_load", {an, seg, err_led, err_count}, {4'hf, 7'h7f, 1'b0, 8'h00});
    tick();
    check("rst_load_blank", {an, seg, err_led, err_count}, {4'hf, 7'h7f, 1'b0, 8'h00});

    // Reset mid-scan at index 2 restarts at index 0.
    do_reset();
    load_at(vecs[0], 16);
    while (cyc < 25) tick();
    check("pre_rst_an", an, 4'b1011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc   = 0;
    check("midscan_rst", {an, seg}, {4'hf, 7'h7f});
    load_at(vecs[0], 16);
    push_scan(vecs[0], 16, 8);
    drain("restart_scan", 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_result_display.md
ADDER_RESULT_DISPLAY -- requirements
Module: adder_result_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clocks per digit slot (1 kHz per digit at 100 MHz); SHALL be >= 2.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  single-cycle strobe; capture current operands and result.
REQ-005 a  input  2  adder operand A.
REQ-006 b  input  2  adder operand B.
REQ-007 cin  input  1  adder carry-in.
REQ-008 s  input  2  adder sum from the upstream adder.
REQ-009 cout  input  1  adder carry-out from the upstream adder.
REQ-010 an  output  4  digit anodes, active-low, an[0] = rightmost digit.
REQ-011 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  output  1  decimal point, active-low; SHALL be constant 1.
REQ-013 err_led  output  1  high when the last captured result mismatched a+b+cin.
REQ-014 err_count  output  8  number of mismatching captures, saturating.

Function
REQ-015 On an edge with load=1, the block SHALL register a, b, cin, and res={cout,s} (3 bits) into capture registers and set a sticky "shown" flag.
REQ-016 On the same edge, err_led SHALL be loaded with ({cout,s} != a+b+cin, computed 3 bits wide) and err_count SHALL increment on mismatch unless already 255.
REQ-017 err_led SHALL hold its value between loads; a matching load SHALL clear it.
REQ-018 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; on the wrap edge the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-019 Digit mapping: index 0 = res (0..7), 1 = cin (0..1), 2 = b (0..3), 3 = a (0..3).
REQ-020 an and seg SHALL be registered: each edge loads an = ~(1<<index) and seg = decode(selected digit) from the index and capture registers held before that edge (one-cycle latency).
REQ-021 Decode table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-022 While shown=0, an SHALL be 1111 and seg 1111111 (blank); prescaler and index SHALL still run.
REQ-023 load asserted mid-slot SHALL NOT disturb prescaler or index; new values SHALL appear on an/seg at the edge after capture.
REQ-024 Back-to-back load cycles SHALL each capture and each be counted; only the last capture is displayed.
REQ-025 Exactly one an bit SHALL be low at any time once shown=1.

Reset
REQ-026 With reset=1 at an edge: prescaler=0, index=0, capture registers=0, shown=0, err_led=0, err_count=0, an=1111, seg=1111111, dp=1.
REQ-027 reset SHALL take priority over a simultaneous load; the load is discarded and not counted.
REQ-028 Reset mid-scan SHALL restart the scan at index 0 with blanked display.

Verification
REQ-029 Reset, no load, REFRESH_DIV=4, 40 cycles -> an=1111, seg=1111111, dp=1, err_led=0, err_count=0 throughout.
REQ-030 load with a=3,b=2,cin=1,cout=1,s=2 -> err_led=0; over 16 cycles an cycles 1110/1101/1011/0111 for 4 cycles each, seg 0000010(6)/1111001(1)/0100100(2)/0110000(3).
REQ-031 load with a=1,b=1,cin=0,{cout,s}=011 -> err_led=1, err_count=1; then load a=1,b=1,cin=0,{cout,s}=010 -> err_led=0, err_count stays 1.
REQ-032 300 consecutive mismatching load cycles -> err_count saturates at 255, no wrap to 0.
REQ-033 reset and load asserted on the same edge with mismatching data -> err_count=0, err_led=0, display blank.
REQ-034 Reset asserted while index=2 after a valid display -> next cycle an=1111, index=0; after a new load, scan starts at an=1110 for a full 4-cycle slot.
